// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit feeding a 2-entry in-order output buffer with valid/ready handshakes.
// Optional head-is-zero flag: define LOGIC_UNIT_ZERO_FLAG_EN to add the zero port.
module logic_unit_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [15:0]      op_count
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] sel,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (sel)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = ~(x | y);
            3'b100:  r = ~(x & y);
            3'b101:  r = ~(x ^ y);
            3'b110:  r = x & ~y;
            default: r = x;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] res_p0;
    logic [WIDTH-1:0] head_p1;
    logic [WIDTH-1:0] tail_p1;
    logic [1:0]       count_p1;
    logic             armed;
    logic             push;
    logic             pop;

    // Stage 0: combinational operation on the offered operands
    assign res_p0    = logic_op(op, a, b);

    // armed holds in_ready low until the first edge after reset release
    assign in_ready  = armed && (count_p1 != 2'd2);
    assign out_valid = (count_p1 != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_p1 <= 2'd0;
            armed    <= 1'b0;
            op_count <= 16'd0;
        end else begin
            armed    <= 1'b1;
            count_p1 <= count_p1 + {1'b0, push} - {1'b0, pop};
            if (push)
                op_count <= op_count + 16'd1;
        end
    end

    // Stage 1: output buffer, head is the oldest entry
    always_ff @(posedge clk) begin
        if (push && pop) begin
            if (count_p1 == 2'd1) begin
                head_p1 <= res_p0;
            end else begin
                head_p1 <= tail_p1;
                tail_p1 <= res_p0;
            end
        end else if (pop) begin
            head_p1 <= tail_p1;
        end else if (push) begin
            if (count_p1 == 2'd0)
                head_p1 <= res_p0;
            else
                tail_p1 <= res_p0;
        end
    end

    assign result = out_valid ? head_p1 : '0;

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    assign zero = out_valid && (head_p1 == '0);
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe: vector table plus handshake, reset and wrap sequences.
module tb_logic_unit_pipe;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [15:0]      op_count;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic             zero;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt;

    logic_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .op(op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .op_count(op_count)
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        ,
        .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[10];
    logic [WIDTH-1:0] seq_exp[4];
    logic [2:0]       seq_op[4];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{3'b000, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0, 64'hF000F000F000F000};
        vecs[1] = '{3'b001, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0, 64'hFFF0FFF0FFF0FFF0};
        vecs[2] = '{3'b010, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0, 64'h0FF00FF00FF00FF0};
        vecs[3] = '{3'b011, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0, 64'h000F000F000F000F};
        vecs[4] = '{3'b100, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0, 64'h0FFF0FFF0FFF0FFF};
        vecs[5] = '{3'b101, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0, 64'hF00FF00FF00FF00F};
        vecs[6] = '{3'b110, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0, 64'h0F000F000F000F00};
        vecs[7] = '{3'b111, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00};
        vecs[8] = '{3'b000, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'h0000000000000000};
        vecs[9] = '{3'b110, 64'hFFFFFFFFFFFFFFFF, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0};
        seq_op[0] = 3'b001; seq_exp[0] = 64'hAAAAAAAAAAAAAAAA;
        seq_op[1] = 3'b010; seq_exp[1] = 64'h0000000000000000;
        seq_op[2] = 3'b011; seq_exp[2] = 64'h5555555555555555;
        seq_op[3] = 3'b100; seq_exp[3] = 64'h5555555555555555;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 3'b000;
        exp_cnt = 16'd0;
        #12;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_op_count", {48'd0, op_count}, 64'd0);
        chk("reset_result", result, 64'd0);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        chk("reset_zero", {63'd0, zero}, 64'd0);
`endif
        rst = 1'b0;
        step();
        chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

        // Single operations, one cycle latency each
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; in_valid = 1'b1;
            step();
            exp_cnt++;
            in_valid = 1'b0; a = '1; b = '1; op = 3'b111;
            chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            chk($sformatf("vec%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].exp == '0});
`endif
            step();
            chk($sformatf("vec%0d_drained", i), {63'd0, out_valid}, 64'd0);
        end
        chk("count_after_table", {48'd0, op_count}, {48'd0, exp_cnt});

        // Back-to-back stream
        a = 64'hAAAAAAAAAAAAAAAA; b = 64'hAAAAAAAAAAAAAAAA; op = seq_op[0]; in_valid = 1'b1;
        step();
        exp_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b%0d_result", i), result, seq_exp[i]);
            chk($sformatf("b2b%0d_ready", i), {63'd0, in_ready}, 64'd1);
            if (i < 3) begin
                op = seq_op[i+1];
                exp_cnt++;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        chk("b2b_drained", {63'd0, out_valid}, 64'd0);

        // Backpressure: fill to two, third offer must be held off
        out_ready = 1'b0; op = 3'b111; b = '0;
        a = 64'd1; in_valid = 1'b1; step(); exp_cnt++;
        a = 64'd2; step(); exp_cnt++;
        a = 64'd3;
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("full_in_ready_hold", {63'd0, in_ready}, 64'd0);
        chk("full_head", result, 64'd1);
        step();
        chk("full_head_stable", result, 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_second", result, 64'd2);
        step();
        exp_cnt++;
        chk("bp_third", result, 64'd3);
        in_valid = 1'b0;
        step();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);
        chk("bp_op_count", {48'd0, op_count}, {48'd0, exp_cnt});

        // Simultaneous push and pop at occupancy 1
        out_ready = 1'b0; a = 64'h11; in_valid = 1'b1;
        step(); exp_cnt++;
        a = 64'h22; out_ready = 1'b1;
        chk("pp_before", result, 64'h11);
        step(); exp_cnt++;
        in_valid = 1'b0;
        chk("pp_after", result, 64'h22);
        chk("pp_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("pp_drained", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset with a full buffer
        out_ready = 1'b0; a = 64'h33; in_valid = 1'b1;
        step();
        a = 64'h44;
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_op_count", {48'd0, op_count}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        exp_cnt = 16'd0;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_empty%0d", i), {63'd0, out_valid}, 64'd0);
        end
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // 65536 streaming pushes, op_count wraps back to zero
        a = 64'hFFFFFFFFFFFFFFFF; b = 64'h0F0F0F0F0F0F0F0F; op = 3'b110; in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            step();
            exp_cnt++;
            if (i == 65535)
                in_valid = 1'b0;
            if (!out_valid || result !== 64'hF0F0F0F0F0F0F0F0)
                chk($sformatf("wrap_result%0d", i), result, 64'hF0F0F0F0F0F0F0F0);
        end
        checks++;
        chk("wrap_op_count", {48'd0, op_count}, 64'd0);
        chk("wrap_op_count_model", {48'd0, op_count}, {48'd0, exp_cnt});
        step();
        chk("wrap_drained", {63'd0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
